spi_cmd_slave: RTL and testbench
================================

SPI_CMD_SLAVE -- requirements
Module: spi_cmd_slave

Interface
REQ-001 The block SHALL have parameter FRAME_W, default 24: command frame length in bits.
REQ-002 The block SHALL have parameter RSP_W, default 8: readback word length in bits; RSP_W != FRAME_W.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: received-frame buffer depth; power of 2, at least 2.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for sclk, mosi and cs_n; at least 2.
REQ-005 The block SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have ports sclk, mosi and cs_n, inputs, 1 bit each: SPI mode 0 pins, asynchronous to clk; sclk frequency at most clk/4.
REQ-008 The block SHALL have port miso, output, 1 bit: SPI data out, registered.
REQ-009 The block SHALL have port frm_data, output, FRAME_W bits: FIFO head frame.
REQ-010 The block SHALL have port frm_valid, output, 1 bit: FIFO not empty.
REQ-011 The block SHALL have port frm_ready, input, 1 bit: consumer pops the head when frm_valid and frm_ready are both high.
REQ-012 The block SHALL have port frm_count, output, $clog2(FIFO_DEPTH+1) bits: number of frames held in the FIFO.
REQ-013 The block SHALL have port rsp_data, input, RSP_W bits: readback word, captured at cs_fall.
REQ-014 The block SHALL have port frm_err, output, 1 bit: one-cycle pulse when a bad-length frame is discarded.
REQ-015 The block SHALL have port ovf, output, 1 bit: one-cycle pulse when a frame is dropped because the FIFO is full.
REQ-016 The block SHALL have port busy, output, 1 bit: synchronised cs_n is low.

Function
REQ-017 sclk, mosi and cs_n SHALL each pass through a SYNC_STAGES flop chain; the edge detectors (sclk_rise, sclk_fall, cs_fall, cs_rise) SHALL compare the last chain stage with a one-cycle-delayed copy of it.
REQ-018 On cs_fall, the block SHALL clear bit_cnt, clear the shift register, load the rsp shifter with rsp_data and drive miso = rsp_data[RSP_W-1] on the next cycle.
REQ-019 On sclk_rise with cs low, the block SHALL shift synchronised mosi into the shift register LSB (MSB first) and increment bit_cnt, saturating at FRAME_W+1.
REQ-020 On sclk_fall with cs low, the rsp shifter SHALL shift left with 0 fill, and miso SHALL present the next bit; after RSP_W bits, miso SHALL be 0.
REQ-021 miso SHALL be 0 whenever synchronised cs_n is high; the block SHALL NOT drive a tristate.
REQ-022 On cs_rise with bit_cnt == FRAME_W, the block SHALL push the shift register contents into the FIFO.
REQ-023 On cs_rise with bit_cnt == RSP_W, the block SHALL treat the frame as readback-only: no push, no frm_err.
REQ-024 On cs_rise with bit_cnt == 0, the block SHALL ignore the event silently.
REQ-025 On cs_rise with any other bit_cnt, the block SHALL discard the frame and pulse frm_err for 1 cycle.
REQ-026 On a push with the FIFO full and no pop in the same cycle, the block SHALL drop the new frame, pulse ovf for 1 cycle and leave the FIFO contents unchanged.
REQ-027 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full; in that case ovf SHALL NOT pulse and frm_count SHALL be unchanged.
REQ-028 A pushed frame SHALL appear on frm_data with frm_valid high on the cycle after the cs_rise detection cycle.
REQ-029 The FIFO SHALL preserve frame order, and frm_data SHALL be stable while frm_valid is high and frm_ready is low.
REQ-030 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 Popping with the FIFO empty SHALL have no effect.

Reset
REQ-032 While rst is high, the block SHALL force the synchroniser chains to sclk=0, mosi=0, cs_n=1 and clear bit_cnt, the shifters and the FIFO pointers.
REQ-033 While rst is high, outputs SHALL be miso=0, frm_valid=0, frm_count=0, frm_err=0, ovf=0, busy=0 and frm_data=0.
REQ-034 A frame interrupted by rst SHALL be lost without frm_err or ovf.
REQ-035 If rst is released while cs_n is low, the remainder of that frame SHALL be judged by REQ-022..REQ-025.

Verification
REQ-036 Frame case: send 24-bit frame 0xA5C33C with frm_ready=0 -> frm_valid=1, frm_data=0xA5C33C, frm_count=1; then frm_ready=1 for 1 cycle -> frm_valid=0, frm_count=0.
REQ-037 Readback case: rsp_data=0x03, 8-clock frame -> miso sequence 0,0,0,0,0,0,1,1 on successive sclk rising edges; frm_err=0, frm_count unchanged.
REQ-038 Bad-length case: 10-bit frame -> exactly one frm_err pulse; frm_count unchanged; a following 24-bit frame is received correctly.
REQ-039 Overflow case: frm_ready=0, five frames 0x000001..0x000005 -> frm_count=4, one ovf pulse on the fifth, pops yield 0x000001..0x000004 in order.
REQ-040 Full-FIFO pop case: FIFO full, frm_ready=1 in the fifth frame's push cycle -> no ovf, frm_count=4, pop order 0x000002..0x000005.
REQ-041 Reset case: rst for 2 cycles after 12 bits of a frame -> frm_valid=0, frm_count=0, miso=0, no frm_err; next frame 0x123456 is received intact.

Source files
------------

// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: SPI mode-0 command receiver with synchronisers, frame FIFO and readback shifter
module spi_cmd_slave #(
  parameter int FRAME_W     = 24,
  parameter int RSP_W       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sclk,
  input  logic                              mosi,
  input  logic                              cs_n,
  output logic                              miso,
  output logic [FRAME_W-1:0]                frm_data,
  output logic                              frm_valid,
  input  logic                              frm_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   frm_count,
  input  logic [RSP_W-1:0]                  rsp_data,
  output logic                              frm_err,
  output logic                              ovf,
  output logic                              busy
);
  localparam int CW = $clog2(FRAME_W + 2);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FRAME = CW'(FRAME_W);
  localparam logic [CW-1:0] CNT_RSP   = CW'(RSP_W);
  localparam logic [CW-1:0] CNT_MAX   = CW'(FRAME_W + 1);
  localparam logic [NW-1:0] CNT_FULL  = NW'(FIFO_DEPTH);
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                   r_sclk_d, r_cs_d;
  logic [CW-1:0]          r_bit_cnt;
  logic [FRAME_W-1:0]     r_shift;
  logic [RSP_W-2:0]       r_rsp;
  logic                   r_miso;
  logic [FRAME_W-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [NW-1:0]          r_count;
  logic                   r_frm_err, r_ovf;
  logic w_sclk, w_mosi, w_cs;
  logic w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise;
  logic w_push, w_bad, w_pop, w_full, w_wr;
  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs        = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_push      = w_cs_rise && r_bit_cnt == CNT_FRAME;
  assign w_bad       = w_cs_rise && r_bit_cnt != '0 && r_bit_cnt != CNT_FRAME && r_bit_cnt != CNT_RSP;
  assign w_pop       = frm_valid & frm_ready;
  assign w_full      = r_count == CNT_FULL;
  assign w_wr        = w_push & (~w_full | w_pop);
  assign frm_valid   = r_count != '0;
  assign frm_count   = r_count;
  assign frm_data    = frm_valid ? r_mem[r_rd_ptr] : '0;
  assign busy        = ~w_cs;
  assign miso        = r_miso;
  assign frm_err     = r_frm_err;
  assign ovf         = r_ovf;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs_n};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end
  always_ff @(posedge clk) begin
    if (rst || w_cs_fall) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_sclk_rise && !w_cs) begin
      r_shift   <= {r_shift[FRAME_W-2:0], w_mosi};
      r_bit_cnt <= (r_bit_cnt == CNT_MAX) ? r_bit_cnt : r_bit_cnt + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp  <= '0;
      r_miso <= 1'b0;
    end else if (w_cs_fall) begin
      r_rsp  <= rsp_data[RSP_W-2:0];
      r_miso <= rsp_data[RSP_W-1];
    end else if (w_cs) begin
      r_miso <= 1'b0;
    end else if (w_sclk_fall) begin
      r_rsp  <= r_rsp << 1;
      r_miso <= r_rsp[RSP_W-2];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && w_wr) r_mem[r_wr_ptr] <= r_shift;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_frm_err <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_wr_ptr  <= w_wr ? r_wr_ptr + AW'(1) : r_wr_ptr;
      r_rd_ptr  <= w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
      r_count   <= (w_wr && !w_pop) ? r_count + NW'(1) : (!w_wr && w_pop) ? r_count - NW'(1) : r_count;
      r_frm_err <= w_bad;
      r_ovf     <= w_push & w_full & ~w_pop;
    end
  end
endmodule

// File: tb/tb_spi_cmd_slave.sv
// tb_spi_cmd_slave: directed self-checking bench for spi_cmd_slave
module tb_spi_cmd_slave;
  logic        clk = 0, rst = 1, sclk = 0, mosi = 0, cs_n = 1, frm_ready = 0;
  logic [7:0]  rsp_data = 0;
  logic        miso, frm_valid, frm_err, ovf, busy;
  logic [23:0] frm_data;
  logic [2:0]  frm_count;
  logic [31:0] got;
  int n_chk = 0, n_err = 0, n_ferr = 0, n_ovf = 0;
  spi_cmd_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
    .frm_data(frm_data), .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_count(frm_count), .rsp_data(rsp_data), .frm_err(frm_err), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (frm_err === 1'b1) n_ferr++;
    if (ovf === 1'b1) n_ovf++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cs_lo();
    @(negedge clk);
    cs_n = 0;
    got = 0;
    repeat (8) @(negedge clk);
  endtask
  task automatic shift_bits(input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = v[i];
      repeat (4) @(negedge clk);
      got = {got[30:0], miso};
      sclk = 1;
      repeat (4) @(negedge clk);
      sclk = 0;
    end
    repeat (4) @(negedge clk);
  endtask
  task automatic cs_hi(input bit pop);
    cs_n = 1;
    mosi = 0;
    if (pop) begin
      repeat (2) @(negedge clk);
      frm_ready = 1;
      @(negedge clk);
      frm_ready = 0;
    end
    repeat (8) @(negedge clk);
  endtask
  task automatic send(input int n, input logic [31:0] v, input bit pop);
    cs_lo();
    shift_bits(n, v);
    cs_hi(pop);
  endtask
  task automatic pop1();
    frm_ready = 1;
    @(negedge clk);
    frm_ready = 0;
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(miso), 0);
    check("rst_valid", 32'(frm_valid), 0);
    check("rst_count", 32'(frm_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_data", 32'(frm_data), 0);
    check("rst_err", 32'(frm_err), 0);
    check("rst_ovf", 32'(ovf), 0);
    rst = 0;
    repeat (4) @(negedge clk);
    send(24, 32'hA5C33C, 0);
    check("frame_valid", 32'(frm_valid), 1);
    check("frame_data", 32'(frm_data), 32'hA5C33C);
    check("frame_count", 32'(frm_count), 1);
    repeat (5) @(negedge clk);
    check("frame_hold", 32'(frm_data), 32'hA5C33C);
    pop1();
    check("frame_pop_valid", 32'(frm_valid), 0);
    check("frame_pop_count", 32'(frm_count), 0);
    rsp_data = 8'h03;
    send(8, 32'h5A, 0);
    check("rdbk_miso", 32'(got[7:0]), 32'h03);
    check("rdbk_err", 32'(n_ferr), 0);
    check("rdbk_count", 32'(frm_count), 0);
    rsp_data = 8'h00;
    send(10, 32'h3FF, 0);
    check("bad_err", 32'(n_ferr), 1);
    check("bad_count", 32'(frm_count), 0);
    send(24, 32'h5A5A5A, 0);
    check("bad_next_data", 32'(frm_data), 32'h5A5A5A);
    check("bad_next_count", 32'(frm_count), 1);
    check("bad_next_err", 32'(n_ferr), 1);
    pop1();
    for (int k = 1; k <= 5; k++) send(24, 32'(k), 0);
    check("ovf_count", 32'(frm_count), 4);
    check("ovf_pulse", 32'(n_ovf), 1);
    for (int k = 1; k <= 4; k++) begin
      check("ovf_order", 32'(frm_data), 32'(k));
      pop1();
    end
    check("ovf_empty", 32'(frm_valid), 0);
    for (int k = 1; k <= 4; k++) send(24, 32'(k), 0);
    send(24, 32'h5, 1);
    check("fpop_ovf", 32'(n_ovf), 1);
    check("fpop_count", 32'(frm_count), 4);
    for (int k = 2; k <= 5; k++) begin
      check("fpop_order", 32'(frm_data), 32'(k));
      pop1();
    end
    check("fpop_empty", 32'(frm_count), 0);
    send(24, 32'h777777, 0);
    check("prerst_count", 32'(frm_count), 1);
    rsp_data = 8'hFF;
    cs_lo();
    check("prerst_busy", 32'(busy), 1);
    check("prerst_miso", 32'(miso), 1);
    shift_bits(12, 32'hABC);
    rst = 1;
    repeat (2) @(negedge clk);
    check("inrst_valid", 32'(frm_valid), 0);
    check("inrst_count", 32'(frm_count), 0);
    check("inrst_miso", 32'(miso), 0);
    check("inrst_busy", 32'(busy), 0);
    check("inrst_data", 32'(frm_data), 0);
    rst = 0;
    repeat (8) @(negedge clk);
    cs_hi(0);
    check("postrst_err", 32'(n_ferr), 1);
    check("postrst_ovf", 32'(n_ovf), 1);
    check("postrst_count", 32'(frm_count), 0);
    send(24, 32'h123456, 0);
    check("postrst_data", 32'(frm_data), 32'h123456);
    check("postrst_count1", 32'(frm_count), 1);
    pop1();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
